// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: state encodings and defaults shared by the frame sequencer.
package frame_seq_pkg;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_START_WAIT = 4'd1;
  localparam logic [3:0] ST_INIT       = 4'd2;
  localparam logic [3:0] ST_LOAD       = 4'd3;
  localparam logic [3:0] ST_DRAW       = 4'd4;
  localparam logic [3:0] ST_CHECK      = 4'd5;
  localparam logic [3:0] ST_WAIT       = 4'd6;
  localparam logic [3:0] ST_ERASE      = 4'd7;
  localparam logic [3:0] ST_OVER       = 4'd8;

  typedef enum logic [3:0] {
    IDLE       = ST_IDLE,
    START_WAIT = ST_START_WAIT,
    INIT       = ST_INIT,
    LOAD       = ST_LOAD,
    DRAW       = ST_DRAW,
    CHECK      = ST_CHECK,
    WAIT       = ST_WAIT,
    ERASE      = ST_ERASE,
    OVER       = ST_OVER
  } state_e;

  localparam int FRAME_WAIT_DEF = 1666666;

endpackage

// File: rtl/frame_wait_timer.sv
// frame_wait_timer: counts 0..LIMIT-1 while enabled, freezes on hold,
// and flags done on the final count.
module frame_wait_timer
  import frame_seq_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int LIMIT = FRAME_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic hold,
  input  logic clear,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign done = en && !hold && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (en && !hold)
      cnt_d = done ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: draw / check / wait / erase frame loop for sprite channels.
// Optional macro FRAME_SEQ_PAUSE_EN lets pause freeze the wait phase.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int NUM_OBJ    = 2,
  parameter int CNT_W      = 8,
  parameter int FRAME_WAIT = FRAME_WAIT_DEF,
  parameter int EDGE_W     = 10,
  localparam int OBJ_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic [EDGE_W-1:0]        touch_edge,
  input  logic [NUM_OBJ*CNT_W-1:0] obj_pix_count,
  output logic                     load_coord,
  output logic                     plot,
  output logic                     erase,
  output logic [OBJ_W-1:0]         obj_sel,
  output logic [CNT_W-1:0]         pix_idx,
  output logic                     move_en,
  output logic                     en_time_control,
  output logic                     reset_out,
  output logic                     game_over,
  output logic [3:0]               state
);

  localparam int TW = $clog2(FRAME_WAIT + 1);

  state_e           state_q, state_d;
  logic [OBJ_W-1:0] obj_q, obj_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q [NUM_OBJ];
  logic [CNT_W-1:0] cnt_d [NUM_OBJ];

  logic             wait_done, hold, scan, idx_last, nxt_ok;
  logic [CNT_W-1:0] cur_cnt;
  logic [OBJ_W-1:0] nxt_obj, first_obj, in_obj;

`ifdef FRAME_SEQ_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold = 1'b0;
`endif

  frame_wait_timer #(
    .WIDTH (TW),
    .LIMIT (FRAME_WAIT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == WAIT),
    .hold  (hold),
    .clear (state_q != WAIT),
    .done  (wait_done)
  );

  assign cur_cnt  = cnt_q[obj_q];
  assign idx_last = ({1'b0, idx_q} + 1'b1) >= {1'b0, cur_cnt};

  // Empty channels are jumped over so they cost no cycles.
  always_comb begin
    nxt_ok    = 1'b0;
    nxt_obj   = '0;
    first_obj = '0;
    in_obj    = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (i > int'(obj_q) && cnt_q[i] != '0) begin
        nxt_ok  = 1'b1;
        nxt_obj = OBJ_W'(i);
      end
      if (cnt_q[i] != '0)
        first_obj = OBJ_W'(i);
      if (obj_pix_count[i*CNT_W +: CNT_W] != '0)
        in_obj = OBJ_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    obj_d   = obj_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:       if (start) state_d = START_WAIT;
      START_WAIT: if (!start) state_d = INIT;
      INIT:       state_d = LOAD;
      LOAD: begin
        state_d = DRAW;
        obj_d   = in_obj;
        idx_d   = '0;
        for (int i = 0; i < NUM_OBJ; i++)
          cnt_d[i] = obj_pix_count[i*CNT_W +: CNT_W];
      end
      DRAW, ERASE: begin
        if (!idx_last) begin
          idx_d = idx_q + 1'b1;
        end else begin
          idx_d = '0;
          if (nxt_ok)
            obj_d = nxt_obj;
          else
            state_d = (state_q == DRAW) ? CHECK : LOAD;
        end
      end
      CHECK: state_d = (|touch_edge) ? OVER : WAIT;
      WAIT: begin
        if (wait_done) begin
          state_d = ERASE;
          obj_d   = first_obj;
          idx_d   = '0;
        end
      end
      OVER:    if (start) state_d = START_WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      obj_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < NUM_OBJ; i++)
        cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      obj_q   <= obj_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign scan            = (state_q == DRAW) || (state_q == ERASE);
  assign plot            = scan && (cur_cnt != '0);
  assign erase           = (state_q == ERASE);
  assign obj_sel         = scan ? obj_q : '0;
  assign pix_idx         = scan ? idx_q : '0;
  assign move_en         = scan || (state_q == WAIT);
  assign en_time_control = move_en;
  assign load_coord      = (state_q == LOAD);
  assign reset_out       = (state_q == INIT);
  assign game_over       = (state_q == OVER);
  assign state           = state_q;

endmodule
